// File: rtl/nx_constants.sv
// Purpose: shared node constants, the instruction type, and the D/Q flop declaration macros.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`ifndef NX_DQ_MACROS
`define NX_DQ_MACROS
// Declares a next-state/state pair D / Q of width W.
`define DECLARE_DQ(W, D, Q) logic [(W)-1:0] D, Q;
// Default assignment for a next-state value: hold the current state.
`define INIT_D(D, Q) D = Q;
`endif

package nx_constants;

  localparam int unsigned NX_MAX_INSTRS  = 512;
  localparam int unsigned NX_INSTR_WIDTH = 15;

  typedef logic [NX_INSTR_WIDTH-1:0] nx_instruction_t;

endpackage

// File: rtl/nx_instr_load_fifo.sv
// Purpose: small synchronous FIFO buffering instruction loads ahead of the RAM write port.
// Latency: an entry pushed in cycle T is at the head (poppable) in T+1; full/empty are registered.
// Backpressure: pushes while full and pops while empty are ignored; flush empties it next cycle
//               and discards any push presented with it.
// Ports: clk_i/rst_i (async active-low), flush_i, push_i/push_data_i, pop_i/pop_data_o (head),
//        full_o, empty_o.
module nx_instr_load_fifo #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  `DECLARE_DQ(PW, wr_ptr_d, wr_ptr_q)
  `DECLARE_DQ(PW, rd_ptr_d, rd_ptr_q)
  `DECLARE_DQ(PW+1, count_d, count_q)

  logic [WIDTH-1:0] store [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == (PW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = store[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    `INIT_D(wr_ptr_d, wr_ptr_q)
    `INIT_D(rd_ptr_d, rd_ptr_q)
    `INIT_D(count_d, count_q)
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) store[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/nx_instr_store.sv
// Purpose: single-ported instruction RAM serving core fetches and appending loads from the message path.
// Latency: fetch data 1 cycle after an accepted read; a pushed load reaches RAM no earlier than the next cycle.
// Backpressure: load_ready_o drops while the load FIFO is full; that state forces a drain and stalls fetch.
// Ports: clk_i/rst_i (async active-low); fetch instr_addr_i/instr_rd_i -> instr_data_o, instr_stall_o;
//        loads load_valid_i/load_data_i/load_ready_o; clear_i; status populated_o, overflow_o.
module nx_instr_store
  import nx_constants::*;
#(
  parameter  int unsigned MAX_INSTRS  = NX_MAX_INSTRS,
  parameter  int unsigned INSTR_WIDTH = NX_INSTR_WIDTH,
  parameter  int unsigned LOAD_DEPTH  = 4,
  localparam int unsigned AW          = $clog2(MAX_INSTRS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AW-1:0]          instr_addr_i,
  input  logic                   instr_rd_i,
  output logic [INSTR_WIDTH-1:0] instr_data_o,
  output logic                   instr_stall_o,
  input  logic                   load_valid_i,
  input  logic [INSTR_WIDTH-1:0] load_data_i,
  output logic                   load_ready_o,
  input  logic                   clear_i,
  output logic [AW-1:0]          populated_o,
  output logic                   overflow_o
);

  `DECLARE_DQ(AW, populated_d, populated_q)
  `DECLARE_DQ(1, overflow_d, overflow_q)
  `DECLARE_DQ(INSTR_WIDTH, instr_data_d, instr_data_q)

  logic [INSTR_WIDTH-1:0] mem [MAX_INSTRS];

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [INSTR_WIDTH-1:0] fifo_head;
  logic                   push;
  logic                   drain;
  logic                   rd_acc;
  logic                   at_cap;
  logic                   wr_en;

  assign push = load_valid_i && !fifo_full;

  // Port arbitration uses only registered FIFO state plus the fetch request:
  // a full FIFO takes the port unconditionally, otherwise fetch wins and
  // loads drain in the gaps.
  assign drain  = fifo_full || (!instr_rd_i && !fifo_empty);
  assign rd_acc = !fifo_full && instr_rd_i;

  // The last address is kept unused so populated_o never wraps within AW bits.
  assign at_cap = (populated_q == AW'(MAX_INSTRS - 1));
  assign wr_en  = drain && !clear_i && !at_cap;

  nx_instr_load_fifo #(
    .WIDTH (INSTR_WIDTH),
    .DEPTH (LOAD_DEPTH)
  ) u_load_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (clear_i),
    .push_i      (push),
    .push_data_i (load_data_i),
    .pop_i       (drain),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    `INIT_D(populated_d, populated_q)
    `INIT_D(overflow_d, overflow_q)
    `INIT_D(instr_data_d, instr_data_q)
    if (rd_acc) instr_data_d = mem[instr_addr_i];
    if (clear_i) begin
      populated_d = '0;
      overflow_d  = '0;
    end else if (drain) begin
      // A drain at capacity still pops the entry; it is dropped and flagged.
      if (at_cap) overflow_d  = 1'b1;
      else        populated_d = populated_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      populated_q  <= '0;
      overflow_q   <= '0;
      instr_data_q <= '0;
    end else begin
      populated_q  <= populated_d;
      overflow_q   <= overflow_d;
      instr_data_q <= instr_data_d;
    end
  end

  // RAM contents survive reset and clear.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[populated_q] <= fifo_head;
  end

  assign instr_data_o  = instr_data_q;
  assign instr_stall_o = fifo_full;
  assign load_ready_o  = !fifo_full;
  assign populated_o   = populated_q;
  assign overflow_o    = overflow_q[0];

endmodule

// File: tb/tb_nx_instr_store.sv
// Purpose: directed bench for nx_instr_store (MAX_INSTRS = 8) with a read-data scoreboard.
// Latency: checks 1-cycle read data, load-to-RAM timing and single-cycle forced-drain stalls.
// Backpressure: exercises FIFO full/stall, capacity overflow, clear and mid-drain async reset.
module tb_nx_instr_store;

  localparam int unsigned MI = 8;
  localparam int unsigned W  = 15;
  localparam int unsigned AW = $clog2(MI);

  logic          clk_i;
  logic          rst_i;
  logic [AW-1:0] instr_addr_i;
  logic          instr_rd_i;
  logic [W-1:0]  instr_data_o;
  logic          instr_stall_o;
  logic          load_valid_i;
  logic [W-1:0]  load_data_i;
  logic          load_ready_o;
  logic          clear_i;
  logic [AW-1:0] populated_o;
  logic          overflow_o;

  nx_instr_store #(
    .MAX_INSTRS  (MI),
    .INSTR_WIDTH (W),
    .LOAD_DEPTH  (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_addr_i  (instr_addr_i),
    .instr_rd_i    (instr_rd_i),
    .instr_data_o  (instr_data_o),
    .instr_stall_o (instr_stall_o),
    .load_valid_i  (load_valid_i),
    .load_data_i   (load_data_i),
    .load_ready_o  (load_ready_o),
    .clear_i       (clear_i),
    .populated_o   (populated_o),
    .overflow_o    (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  logic         pend = 1'b0;
  logic [W-1:0] e_mon;

  // Monitor: a read accepted in one cycle is compared one cycle later.
  always @(negedge clk_i) begin
    if (pend) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_data: got 0x%0h with no read expected", instr_data_o);
      end else begin
        e_mon = exp_q.pop_front();
        if (instr_data_o !== e_mon) begin
          n_err++;
          $display("FAIL rd_data: got 0x%0h expected 0x%0h", instr_data_o, e_mon);
        end
      end
    end
    pend = rst_i && instr_rd_i && !instr_stall_o;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One bus cycle, entered and left at posedge+1. A read the DUT does not
  // stall gets its expected data queued for the monitor.
  task automatic cyc(input logic rd, input logic [AW-1:0] a, input logic [W-1:0] exp,
                     input logic lv, input logic [W-1:0] ld, input logic clr,
                     output logic rd_ok, output logic ld_ok);
    instr_rd_i   = rd;
    instr_addr_i = a;
    load_valid_i = lv;
    load_data_i  = ld;
    clear_i      = clr;
    @(negedge clk_i);
    rd_ok = rd && !instr_stall_o && rst_i;
    ld_ok = lv && load_ready_o && rst_i;
    if (rd_ok) exp_q.push_back(exp);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    logic o1, o2;
    for (int j = 0; j < n; j++) cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, o1, o2);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] exp);
    logic o1, o2;
    cyc(1'b1, a, exp, 1'b0, '0, 1'b0, o1, o2);
  endtask

  task automatic ld(input logic r, input logic [AW-1:0] a, input logic [W-1:0] exp, input logic [W-1:0] d);
    logic o1, o2;
    cyc(r, a, exp, 1'b1, d, 1'b0, o1, o2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [AW-1:0] a2 [8] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
  logic [W-1:0]  e2 [8] = '{15'h11, 15'h22, 15'h33, 15'h11, 15'h22, 15'h33, 15'h41, 15'h11};

  initial begin
    logic ok, lok;
    int   i, k, n, stalls;

    rst_i = 1'b0; instr_rd_i = 1'b0; instr_addr_i = '0;
    load_valid_i = 1'b0; load_data_i = '0; clear_i = 1'b0;
    #3;
    chk("rst_data", 32'(instr_data_o), 32'h0);
    chk("rst_stall", 32'(instr_stall_o), 32'h0);
    chk("rst_ready", 32'(load_ready_o), 32'h1);
    chk("rst_populated", 32'(populated_o), 32'h0);
    chk("rst_overflow", 32'(overflow_o), 32'h0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b1;
    idle(1);
    chk("idle_populated", 32'(populated_o), 32'h0);

    // Three loads with fetch idle drain opportunistically.
    ld(1'b0, '0, '0, 15'h11);
    ld(1'b0, '0, '0, 15'h22);
    ld(1'b0, '0, '0, 15'h33);
    chk("t1_populated_mid", 32'(populated_o), 32'h2);
    idle(1);
    chk("t1_populated", 32'(populated_o), 32'h3);
    rd(3'd0, 15'h11);
    rd(3'd1, 15'h22);
    rd(3'd2, 15'h33);
    idle(1);

    // Back-to-back fetch while four loads fill the FIFO.
    i = 0; k = 0; n = 0; stalls = 0;
    while (i < 8 && n < 30) begin
      cyc(1'b1, a2[i], e2[i], k < 4, 15'h41 + 15'(k), 1'b0, ok, lok);
      if (lok) k++;
      if (ok) i++;
      if (instr_stall_o) stalls++;
      if (n == 3) begin
        chk("t2_ready_full", 32'(load_ready_o), 32'h0);
        chk("t2_stall", 32'(instr_stall_o), 32'h1);
        chk("t2_populated_pre", 32'(populated_o), 32'h3);
      end
      if (n == 4) begin
        chk("t2_unstall", 32'(instr_stall_o), 32'h0);
        chk("t2_populated_post", 32'(populated_o), 32'h4);
        chk("t2_data_held", 32'(instr_data_o), 32'h11);
        chk("t2_ready_back", 32'(load_ready_o), 32'h1);
      end
      n++;
    end
    chk("t2_fetch_done", 32'(i), 32'd8);
    chk("t2_stall_cycles", 32'(stalls), 32'd1);

    // Queue holds 0x42..0x44; drain one, queue one more, then clear.
    idle(1);
    ld(1'b1, 3'd4, 15'h42, 15'h45);
    chk("t5_populated", 32'(populated_o), 32'h5);
    cyc(1'b1, 3'd0, 15'h11, 1'b1, 15'h99, 1'b1, ok, lok);
    chk("t5_clr_populated", 32'(populated_o), 32'h0);
    chk("t5_clr_overflow", 32'(overflow_o), 32'h0);
    chk("t5_clr_ready", 32'(load_ready_o), 32'h1);
    idle(3);
    chk("t5_fifo_empty", 32'(populated_o), 32'h0);
    ld(1'b0, '0, '0, 15'h51);
    ld(1'b0, '0, '0, 15'h52);
    idle(2);
    chk("t5_reload_populated", 32'(populated_o), 32'h2);
    rd(3'd0, 15'h51);
    rd(3'd1, 15'h52);

    // Level 2, then simultaneous push and pop.
    ld(1'b1, 3'd0, 15'h51, 15'h61);
    ld(1'b1, 3'd1, 15'h52, 15'h62);
    ld(1'b0, '0, '0, 15'h63);
    chk("t3_stall", 32'(instr_stall_o), 32'h0);
    chk("t3_ready", 32'(load_ready_o), 32'h1);
    chk("t3_populated_a", 32'(populated_o), 32'h3);
    ld(1'b0, '0, '0, 15'h64);
    chk("t3_stall_b", 32'(instr_stall_o), 32'h0);
    chk("t3_populated_b", 32'(populated_o), 32'h4);
    idle(3);
    chk("t3_populated", 32'(populated_o), 32'h6);
    rd(3'd2, 15'h61);
    rd(3'd3, 15'h62);
    rd(3'd4, 15'h63);
    rd(3'd5, 15'h64);

    // Capacity: nine loads into an empty store holding at most seven.
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, ok, lok);
    chk("t4_clr_populated", 32'(populated_o), 32'h0);
    k = 0; n = 0;
    while (k < 9 && n < 40) begin
      cyc(n < 4, 3'd0, 15'h51, 1'b1, 15'h81 + 15'(k), 1'b0, ok, lok);
      if (lok) k++;
      if (n == 3) begin
        chk("t4_stall_full", 32'(instr_stall_o), 32'h1);
        chk("t4_ready_full", 32'(load_ready_o), 32'h0);
      end
      n++;
    end
    chk("t4_loads_accepted", 32'(k), 32'd9);
    idle(4);
    chk("t4_populated", 32'(populated_o), 32'h7);
    chk("t4_overflow", 32'(overflow_o), 32'h1);
    chk("t4_ready", 32'(load_ready_o), 32'h1);
    chk("t4_stall", 32'(instr_stall_o), 32'h0);
    for (int j = 0; j < 7; j++) rd(AW'(j), 15'h81 + 15'(j));
    idle(1);

    // Clear drops overflow, then async reset during a forced drain.
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, ok, lok);
    chk("t6_clr_overflow", 32'(overflow_o), 32'h0);
    for (int j = 0; j < 4; j++) ld(1'b1, 3'd1, 15'h82, 15'h91 + 15'(j));
    chk("t6_stall_pre", 32'(instr_stall_o), 32'h1);
    chk("t6_populated_pre", 32'(populated_o), 32'h0);
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("t6_async_stall", 32'(instr_stall_o), 32'h0);
    chk("t6_async_populated", 32'(populated_o), 32'h0);
    chk("t6_async_data", 32'(instr_data_o), 32'h0);
    chk("t6_async_ready", 32'(load_ready_o), 32'h1);
    instr_rd_i = 1'b0; load_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    rd(3'd1, 15'h82);
    chk("t6_first_read", 32'(instr_data_o), 32'h82);
    idle(3);
    chk("t6_queue_abandoned", 32'(populated_o), 32'h0);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
